// File: rtl/axi_log_pkg.sv
// Shared types for the AXI request log arbiter.
package axi_log_pkg;

    localparam int unsigned DEF_ADDR_BITW = 32;
    localparam int unsigned DEF_ID_BITW   = 8;
    localparam int unsigned DEF_LEN_BITW  = 8;

    localparam logic CH_AR = 1'b0;
    localparam logic CH_AW = 1'b1;

    typedef struct packed {
        logic                     is_write;
        logic [DEF_ID_BITW-1:0]   id;
        logic [DEF_ADDR_BITW-1:0] addr;
        logic [DEF_LEN_BITW-1:0]  len;
    } log_entry_t;

endpackage

// File: rtl/axi_log_arbiter_fifo.sv
// Per-channel entry FIFO; accepts a push while full if a pop happens too.
module log_fifo
    import axi_log_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  log_entry_t data_i,
    output logic       full_o,
    output logic       empty_o,
    output log_entry_t head_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    log_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;

    // Extra pointer bit separates full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i && (!full_o || pop_i)) begin
                mem_d[wr_ptr_q[PW-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/axi_log_arbiter.sv
// Merges snooped AR/AW handshakes into one logger write stream, round-robin.
module axi_log_arbiter
    import axi_log_pkg::*;
#(
    parameter int unsigned AXI_ADDR_BITW = DEF_ADDR_BITW,
    parameter int unsigned AXI_ID_BITW   = DEF_ID_BITW,
    parameter int unsigned AXI_LEN_BITW  = DEF_LEN_BITW,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned DROP_CNT_BITW = 16
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RBI,
    input  logic                     ArValid_SI,
    input  logic                     ArReady_SI,
    input  logic [AXI_ID_BITW-1:0]   ArId_DI,
    input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
    input  logic                     AwValid_SI,
    input  logic                     AwReady_SI,
    input  logic [AXI_ID_BITW-1:0]   AwId_DI,
    input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
    input  logic                     Clear_SI,
    input  logic                     LogFull_SI,
    output logic                     LogValid_SO,
    output logic [AXI_ID_BITW-1:0]   LogId_DO,
    output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
    output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
    output logic                     LogIsWrite_SO,
    output logic [DROP_CNT_BITW-1:0] DropCntAr_DO,
    output logic [DROP_CNT_BITW-1:0] DropCntAw_DO
);

    localparam logic [DROP_CNT_BITW-1:0] CNT_ONE = 1;

    log_entry_t ar_entry, aw_entry;
    log_entry_t ar_head, aw_head;
    log_entry_t out_q, out_d;

    logic ar_full, ar_empty, aw_full, aw_empty;
    logic push_ok, ar_evt, aw_evt;
    logic ar_push, aw_push, ar_drop, aw_drop;
    logic grant_ar, grant_aw;
    logic prio_q, prio_d;
    logic valid_q, valid_d;
    logic [DROP_CNT_BITW-1:0] drop_ar_q, drop_ar_d;
    logic [DROP_CNT_BITW-1:0] drop_aw_q, drop_aw_d;

    assign ar_entry = '{is_write: CH_AR, id: ArId_DI,
                        addr: ArAddr_DI, len: ArLen_DI};
    assign aw_entry = '{is_write: CH_AW, id: AwId_DI,
                        addr: AwAddr_DI, len: AwLen_DI};

    assign ar_evt  = ArValid_SI && ArReady_SI;
    assign aw_evt  = AwValid_SI && AwReady_SI;
    assign push_ok = !Clear_SI && !LogFull_SI;

    assign grant_ar = !Clear_SI && !ar_empty &&
                      (aw_empty || prio_q == CH_AR);
    assign grant_aw = !Clear_SI && !aw_empty && !grant_ar;

    // A full FIFO still takes the event when it is popped this cycle.
    assign ar_push = ar_evt && push_ok && (!ar_full || grant_ar);
    assign aw_push = aw_evt && push_ok && (!aw_full || grant_aw);
    assign ar_drop = ar_evt && push_ok && ar_full && !grant_ar;
    assign aw_drop = aw_evt && push_ok && aw_full && !grant_aw;

    log_fifo #(.DEPTH(FIFO_DEPTH)) u_ar_fifo (
        .clk     (Clk_CI),
        .rst_n   (Rst_RBI),
        .push_i  (ar_push),
        .pop_i   (grant_ar),
        .flush_i (Clear_SI),
        .data_i  (ar_entry),
        .full_o  (ar_full),
        .empty_o (ar_empty),
        .head_o  (ar_head)
    );

    log_fifo #(.DEPTH(FIFO_DEPTH)) u_aw_fifo (
        .clk     (Clk_CI),
        .rst_n   (Rst_RBI),
        .push_i  (aw_push),
        .pop_i   (grant_aw),
        .flush_i (Clear_SI),
        .data_i  (aw_entry),
        .full_o  (aw_full),
        .empty_o (aw_empty),
        .head_o  (aw_head)
    );

    always_comb begin
        valid_d   = 1'b0;
        out_d     = out_q;
        prio_d    = prio_q;
        drop_ar_d = drop_ar_q;
        drop_aw_d = drop_aw_q;
        if (Clear_SI) begin
            prio_d    = CH_AR;
            drop_ar_d = '0;
            drop_aw_d = '0;
        end else begin
            unique case (1'b1)
                grant_ar: begin
                    valid_d = 1'b1;
                    out_d   = ar_head;
                    prio_d  = CH_AW;
                end
                grant_aw: begin
                    valid_d = 1'b1;
                    out_d   = aw_head;
                    prio_d  = CH_AR;
                end
                default: ;
            endcase
            if (ar_drop && drop_ar_q != '1) begin
                drop_ar_d = drop_ar_q + CNT_ONE;
            end
            if (aw_drop && drop_aw_q != '1) begin
                drop_aw_d = drop_aw_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            valid_q   <= 1'b0;
            out_q     <= '0;
            prio_q    <= CH_AR;
            drop_ar_q <= '0;
            drop_aw_q <= '0;
        end else begin
            valid_q   <= valid_d;
            out_q     <= out_d;
            prio_q    <= prio_d;
            drop_ar_q <= drop_ar_d;
            drop_aw_q <= drop_aw_d;
        end
    end

    assign LogValid_SO   = valid_q;
    assign LogId_DO      = out_q.id;
    assign LogAddr_DO    = out_q.addr;
    assign LogLen_DO     = out_q.len;
    assign LogIsWrite_SO = out_q.is_write;
    assign DropCntAr_DO  = drop_ar_q;
    assign DropCntAw_DO  = drop_aw_q;

endmodule

// File: tb/tb_axi_log_arbiter.sv
// Bench for axi_log_arbiter: directed table, corner sequences, random vs queue model.
module tb_axi_log_arbiter;

    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 65535;

    typedef struct packed {
        logic        w;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ent_t;

    typedef struct {
        bit         arv, arr, awv, awr, clr, lf;
        logic [7:0] ar_id, aw_id;
        bit         ev, ew;
        logic [7:0] eid;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ar_v, ar_r, aw_v, aw_r, clr, lfull;
    logic [7:0]  ar_id, aw_id, ar_len, aw_len;
    logic [31:0] ar_addr, aw_addr;

    logic        LogValid_SO, LogIsWrite_SO;
    logic [7:0]  LogId_DO, LogLen_DO;
    logic [31:0] LogAddr_DO;
    logic [15:0] DropCntAr_DO, DropCntAw_DO;

    always #5 clk = ~clk;

    axi_log_arbiter dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .ArValid_SI    (ar_v),
        .ArReady_SI    (ar_r),
        .ArId_DI       (ar_id),
        .ArAddr_DI     (ar_addr),
        .ArLen_DI      (ar_len),
        .AwValid_SI    (aw_v),
        .AwReady_SI    (aw_r),
        .AwId_DI       (aw_id),
        .AwAddr_DI     (aw_addr),
        .AwLen_DI      (aw_len),
        .Clear_SI      (clr),
        .LogFull_SI    (lfull),
        .LogValid_SO   (LogValid_SO),
        .LogId_DO      (LogId_DO),
        .LogAddr_DO    (LogAddr_DO),
        .LogLen_DO     (LogLen_DO),
        .LogIsWrite_SO (LogIsWrite_SO),
        .DropCntAr_DO  (DropCntAr_DO),
        .DropCntAw_DO  (DropCntAw_DO)
    );

    int total = 0;
    int bad = 0;
    int pulses = 0;

    ent_t qa[$];
    ent_t qw[$];
    bit   m_prio;
    bit   m_v;
    ent_t m_ent;
    int   m_dar, m_daw;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [7:0] id);
        return 32'h1000_0000 | {20'h0, id, 4'h0};
    endfunction

    function automatic logic [7:0] len_of(input logic [7:0] id);
        return id ^ 8'h5A;
    endfunction

    task automatic set_idle();
        ar_v = 0; ar_r = 0; aw_v = 0; aw_r = 0; clr = 0; lfull = 0;
        ar_id = 0; aw_id = 0; ar_len = 0; aw_len = 0;
        ar_addr = 0; aw_addr = 0;
    endtask

    task automatic ar_hs(input logic [7:0] id);
        ar_v = 1; ar_r = 1; ar_id = id;
        ar_addr = addr_of(id); ar_len = len_of(id);
    endtask

    task automatic aw_hs(input logic [7:0] id);
        aw_v = 1; aw_r = 1; aw_id = id;
        aw_addr = addr_of(id); aw_len = len_of(id);
    endtask

    task automatic model_reset();
        qa.delete();
        qw.delete();
        m_prio = 0;
        m_v = 0;
        m_ent = '0;
        m_dar = 0;
        m_daw = 0;
    endtask

    // What the upcoming edge should do given the current inputs.
    task automatic model_step();
        bit ga, gw;
        if (clr) begin
            qa.delete();
            qw.delete();
            m_v = 0;
            m_prio = 0;
            m_dar = 0;
            m_daw = 0;
        end else begin
            ga = qa.size() > 0 && (qw.size() == 0 || m_prio == 0);
            gw = !ga && qw.size() > 0;
            m_v = ga || gw;
            if (ga) begin
                m_ent = qa.pop_front();
                m_prio = 1;
            end else if (gw) begin
                m_ent = qw.pop_front();
                m_prio = 0;
            end
            if (!lfull) begin
                if (ar_v && ar_r) begin
                    if (qa.size() < DEPTH) qa.push_back({1'b0, ar_id, ar_addr, ar_len});
                    else if (m_dar < CNT_MAX) m_dar++;
                end
                if (aw_v && aw_r) begin
                    if (qw.size() < DEPTH) qw.push_back({1'b1, aw_id, aw_addr, aw_len});
                    else if (m_daw < CNT_MAX) m_daw++;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("valid", LogValid_SO, m_v);
        chk("is_write", LogIsWrite_SO, m_ent.w);
        chk("id", LogId_DO, m_ent.id);
        chk("addr", LogAddr_DO, m_ent.addr);
        chk("len", LogLen_DO, m_ent.len);
        chk("drop_ar", DropCntAr_DO, m_dar);
        chk("drop_aw", DropCntAw_DO, m_daw);
        if (LogValid_SO) pulses++;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, LogValid_SO, 0);
        chk({nm, "_id"}, LogId_DO, 0);
        chk({nm, "_addr"}, LogAddr_DO, 0);
        chk({nm, "_len"}, LogLen_DO, 0);
        chk({nm, "_wr"}, LogIsWrite_SO, 0);
        chk({nm, "_dar"}, DropCntAr_DO, 0);
        chk({nm, "_daw"}, DropCntAw_DO, 0);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1;
        #1;
        rst_n = 0;
        #1;
        chk_zero("rst");
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1;
    endtask

    initial begin
        int n;
        int diff;
        set_idle();
        tbl[0] = '{1, 1, 1, 1, 0, 0, 8'h20, 8'h30, 0, 0, 8'h00};
        tbl[1] = '{1, 1, 1, 1, 0, 0, 8'h21, 8'h31, 1, 0, 8'h20};
        tbl[2] = '{1, 1, 1, 1, 0, 0, 8'h22, 8'h32, 1, 1, 8'h30};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h21};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h31};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h22};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h32};
        tbl[7] = '{0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};

        // Single AR handshake: visible only two cycles later.
        do_reset();
        ar_v = 1; ar_r = 1; ar_id = 8'h12;
        ar_addr = 32'h1000_0040; ar_len = 8'd3;
        cyc();
        chk("t1_c1_valid", LogValid_SO, 0);
        set_idle();
        cyc();
        chk("t1_c2_valid", LogValid_SO, 1);
        chk("t1_c2_wr", LogIsWrite_SO, 0);
        chk("t1_c2_id", LogId_DO, 8'h12);
        chk("t1_c2_addr", LogAddr_DO, 32'h1000_0040);
        chk("t1_c2_len", LogLen_DO, 8'd3);
        cyc();
        chk("t1_c3_valid", LogValid_SO, 0);

        // Interleaved AR/AW from a fresh reset.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_idle();
            ar_v = tbl[i].arv; ar_r = tbl[i].arr;
            aw_v = tbl[i].awv; aw_r = tbl[i].awr;
            clr = tbl[i].clr; lfull = tbl[i].lf;
            ar_id = tbl[i].ar_id; ar_addr = addr_of(tbl[i].ar_id);
            ar_len = len_of(tbl[i].ar_id);
            aw_id = tbl[i].aw_id; aw_addr = addr_of(tbl[i].aw_id);
            aw_len = len_of(tbl[i].aw_id);
            cyc();
            chk("tbl_valid", LogValid_SO, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_wr", LogIsWrite_SO, tbl[i].ew);
                chk("tbl_id", LogId_DO, tbl[i].eid);
                chk("tbl_addr", LogAddr_DO, addr_of(tbl[i].eid));
                chk("tbl_len", LogLen_DO, len_of(tbl[i].eid));
            end
        end

        // Saturation load: entries plus drops account for every event.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            ar_hs(8'(i));
            aw_hs(8'(8'h80 + i));
            cyc();
        end
        set_idle();
        repeat (12) cyc();
        chk("sat_sum", pulses + int'(DropCntAr_DO) + int'(DropCntAw_DO), 40);
        diff = int'(DropCntAr_DO) - int'(DropCntAw_DO);
        chk("sat_diff_le1", (diff <= 1 && diff >= -1), 1);

        // Valid without ready, then handshakes while the logger is full.
        do_reset();
        pulses = 0;
        ar_v = 1; ar_r = 0; ar_id = 8'h44;
        repeat (10) cyc();
        set_idle();
        lfull = 1;
        for (int i = 0; i < 5; i++) begin
            aw_hs(8'(8'h50 + i));
            cyc();
        end
        set_idle();
        repeat (3) cyc();
        chk("nohs_pulses", pulses, 0);
        chk("nohs_dar", DropCntAr_DO, 0);
        chk("nohs_daw", DropCntAw_DO, 0);

        // Clear with entries pending and a nonzero drop count.
        do_reset();
        n = 0;
        while (m_daw < 7 && n < 60) begin
            ar_hs(8'($urandom));
            aw_hs(8'($urandom));
            cyc();
            n++;
        end
        chk("pre_clr_daw", DropCntAw_DO, 7);
        chk("pre_clr_pending", (qa.size() + qw.size() >= 3), 1);
        set_idle();
        clr = 1;
        cyc();
        clr = 0;
        chk("clr_c1_valid", LogValid_SO, 0);
        chk("clr_c1_dar", DropCntAr_DO, 0);
        chk("clr_c1_daw", DropCntAw_DO, 0);
        cyc();
        chk("clr_c2_valid", LogValid_SO, 0);
        ar_hs(8'h77);
        cyc();
        chk("clr_c3_valid", LogValid_SO, 0);
        set_idle();
        cyc();
        chk("clr_c4_valid", LogValid_SO, 1);
        chk("clr_c4_wr", LogIsWrite_SO, 0);
        chk("clr_c4_id", LogId_DO, 8'h77);

        // Asynchronous reset between edges in the middle of a burst.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ar_hs(8'(8'h10 + i));
            aw_hs(8'(8'h90 + i));
            cyc();
        end
        #3;
        rst_n = 0;
        #1;
        chk_zero("async");
        model_reset();
        set_idle();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1;
        ar_hs(8'h5A);
        aw_hs(8'h6B);
        cyc();
        chk("post_rst_c1_valid", LogValid_SO, 0);
        set_idle();
        cyc();
        chk("post_rst_c2_valid", LogValid_SO, 1);
        chk("post_rst_c2_wr", LogIsWrite_SO, 0);
        chk("post_rst_c2_id", LogId_DO, 8'h5A);
        cyc();
        chk("post_rst_c3_valid", LogValid_SO, 1);
        chk("post_rst_c3_wr", LogIsWrite_SO, 1);
        chk("post_rst_c3_id", LogId_DO, 8'h6B);
        cyc();
        chk("post_rst_c4_valid", LogValid_SO, 0);

        // Random traffic against the queue model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ar_v = ($urandom_range(0, 3) != 0);
            ar_r = ($urandom_range(0, 2) != 0);
            aw_v = ($urandom_range(0, 3) != 0);
            aw_r = ($urandom_range(0, 2) != 0);
            ar_id = 8'($urandom); ar_addr = $urandom; ar_len = 8'($urandom);
            aw_id = 8'($urandom); aw_addr = $urandom; aw_len = 8'($urandom);
            clr = ($urandom_range(0, 59) == 0);
            lfull = ($urandom_range(0, 7) == 0);
            cyc();
        end
        set_idle();
        repeat (10) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
